// File: rtl/wb_queue.sv
// Write-back queue: circular FIFO of {dst, data} register-file writes with pending lookup.
// Optional forwarding of youngest matching data enabled by macro WBQ_BYPASS_EN.
module wb_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_dst,
    input  logic [31:0]            in_data,
    output logic                   wr_en,
    input  logic                   wr_ready,
    output logic [4:0]             wr_addr,
    output logic [31:0]            wr_data,
    input  logic [4:0]             rs,
    input  logic [4:0]             rt,
    output logic                   rs_pending,
    output logic                   rt_pending,
    output logic [31:0]            rs_fwd,
    output logic [31:0]            rt_fwd,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } entry_t;

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    entry_t           mem_q [DEPTH];

    logic push;
    logic pop;

    // Status and handshakes derive from registered count only.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == CW'(0));
    assign count    = count_q;
    assign in_ready = !full;
    assign wr_en    = !empty;

    // Writes to r0 are acknowledged but never stored.
    assign push = in_valid && in_ready && (in_dst != 5'd0);
    assign pop  = wr_en && wr_ready;

    assign wr_addr = empty ? 5'd0  : mem_q[head_q].dst;
    assign wr_data = empty ? 32'd0 : mem_q[head_q].data;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + AW'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage needs no reset; valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[tail_q].dst  <= in_dst;
            mem_q[tail_q].data <= in_data;
        end
    end

    // Pending lookup spans every valid entry, including a head being popped.
    always_comb begin
        rs_pending = 1'b0;
        rt_pending = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[AW'(i)] && (rs != 5'd0) && (mem_q[AW'(i)].dst == rs)) rs_pending = 1'b1;
            if (valid_q[AW'(i)] && (rt != 5'd0) && (mem_q[AW'(i)].dst == rt)) rt_pending = 1'b1;
        end
    end

`ifdef WBQ_BYPASS_EN
    // Walk oldest to youngest so the last match is the youngest producer.
    always_comb begin
        logic [AW-1:0] idx;
        idx    = head_q;
        rs_fwd = 32'd0;
        rt_fwd = 32'd0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + AW'(k);
            if (valid_q[idx] && (rs != 5'd0) && (mem_q[idx].dst == rs)) rs_fwd = mem_q[idx].data;
            if (valid_q[idx] && (rt != 5'd0) && (mem_q[idx].dst == rt)) rt_fwd = mem_q[idx].data;
        end
    end
`else
    assign rs_fwd = 32'd0;
    assign rt_fwd = 32'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed plus random bench for wb_queue using a reference-queue scoreboard.
module tb_wb_queue;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } ent_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dst;
    logic [31:0] in_data;
    logic        wr_en;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs, rt;
    logic        rs_pending, rt_pending;
    logic [31:0] rs_fwd, rt_fwd;
    logic [$clog2(DEPTH):0] count;
    logic        full, empty;

    int checks = 0;
    int errors = 0;
    ent_t sb [$];

    wb_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_dst(in_dst), .in_data(in_data),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs(rs), .rt(rt), .rs_pending(rs_pending), .rt_pending(rt_pending),
        .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
        .count(count), .full(full), .empty(empty)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check every output against the model, then clock one cycle and update the model.
    task automatic drive(input logic v, input logic [4:0] d, input logic [31:0] x,
                         input logic wrr, input logic [4:0] a, input logic [4:0] b);
        int unsigned sz;
        logic        epa, epb, accept, popq;
        logic [31:0] efa, efb;
        ent_t        e;
        in_valid = v; in_dst = d; in_data = x; wr_ready = wrr; rs = a; rt = b;
        #1;
        sz = sb.size();
        epa = 1'b0; epb = 1'b0; efa = 32'd0; efb = 32'd0;
        for (int i = 0; i < sb.size(); i++) begin
            if (a != 5'd0 && sb[i].dst == a) epa = 1'b1;
            if (b != 5'd0 && sb[i].dst == b) epb = 1'b1;
`ifdef WBQ_BYPASS_EN
            if (a != 5'd0 && sb[i].dst == a) efa = sb[i].data;
            if (b != 5'd0 && sb[i].dst == b) efb = sb[i].data;
`endif
        end
        chk("count", 32'(count), 32'(sz));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
        chk("wr_en", 32'(wr_en), 32'(sz != 0));
        chk("wr_addr", 32'(wr_addr), (sz != 0) ? 32'(sb[0].dst) : 32'd0);
        chk("wr_data", wr_data, (sz != 0) ? sb[0].data : 32'd0);
        chk("rs_pending", 32'(rs_pending), 32'(epa));
        chk("rt_pending", 32'(rt_pending), 32'(epb));
        chk("rs_fwd", rs_fwd, efa);
        chk("rt_fwd", rt_fwd, efb);
        accept = v && (sz < DEPTH) && (d != 5'd0);
        popq   = (sz != 0) && wrr;
        if (popq) begin
            e = sb.pop_front();
            chk("pop_addr", 32'(wr_addr), 32'(e.dst));
            chk("pop_data", wr_data, e.data);
        end
        if (accept) sb.push_back('{dst: d, data: x});
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; in_valid = 1'b1; in_dst = 5'd9; in_data = 32'hDEAD0000; wr_ready = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        sb.delete();
    endtask

    initial begin
        RST = 1'b0; in_valid = 1'b0; in_dst = '0; in_data = '0; wr_ready = 1'b0; rs = '0; rt = '0;
        do_reset();

        // Reset state
        in_valid = 1'b0; wr_ready = 1'b0; #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);

        // Single push becomes visible the following cycle
        drive(1, 5'd5, 32'h11111111, 0, 5'd5, 5'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd5, 5'd3);
        chk("r36_wr_en", 32'(wr_en), 32'd1);
        chk("r36_wr_addr", 32'(wr_addr), 32'd5);
        chk("r36_wr_data", wr_data, 32'h11111111);
        chk("r36_count", 32'(count), 32'd1);
        chk("r36_rs_pending", 32'(rs_pending), 32'd1);

        // Fill to full; fifth offer held, even across a pop while full
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1, 5'(i), 32'(32'hA0 + i), 0, 5'(i), 5'd4);
        chk("r37_full", 32'(full), 32'd1);
        chk("r37_in_ready", 32'(in_ready), 32'd0);
        drive(1, 5'd5, 32'hA5, 0, 5'd5, 5'd1);
        drive(1, 5'd5, 32'hA5, 1, 5'd1, 5'd5);
        chk("r37_count_after_pop", 32'(count), 32'd3);
        drive(1, 5'd5, 32'hA5, 0, 5'd5, 5'd2);
        chk("r37_count_refill", 32'(count), 32'd4);
        for (int i = 0; i < 5; i++) drive(0, 5'd0, 32'd0, 1, 5'd5, 5'd4);

        // Writes to r0 are discarded
        drive(1, 5'd0, 32'h12345678, 0, 5'd0, 5'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
        chk("r38_count", 32'(count), 32'd0);
        chk("r38_wr_en", 32'(wr_en), 32'd0);

        // Duplicate destination: youngest forwarded, both written in order
        drive(1, 5'd7, 32'hA, 0, 5'd7, 5'd7);
        drive(1, 5'd7, 32'hB, 0, 5'd7, 5'd7);
        drive(0, 5'd0, 32'd0, 0, 5'd7, 5'd7);
`ifdef WBQ_BYPASS_EN
        chk("r39_rs_fwd", rs_fwd, 32'hB);
`else
        chk("r39_rs_fwd", rs_fwd, 32'h0);
`endif
        chk("r39_first_write", wr_data, 32'hA);
        drive(0, 5'd0, 32'd0, 1, 5'd7, 5'd7);
        chk("r39_second_write", wr_data, 32'hB);
        drive(0, 5'd0, 32'd0, 1, 5'd7, 5'd0);

        // Steady push/pop at count 2 across pointer wrap
        drive(1, 5'd3, 32'h300, 0, 5'd3, 5'd0);
        drive(1, 5'd4, 32'h400, 0, 5'd3, 5'd4);
        for (int i = 0; i < 10; i++) drive(1, 5'(10 + i), 32'(32'hC00 + i), 1, 5'(10 + i), 5'(9 + i));
        chk("r40_count", 32'(count), 32'd2);
        drive(0, 5'd0, 32'd0, 1, 5'd18, 5'd19);
        drive(0, 5'd0, 32'd0, 1, 5'd18, 5'd19);

        // Reset overrides push and pop at count 3
        for (int i = 0; i < 3; i++) drive(1, 5'(20 + i), 32'(32'hE0 + i), 0, 5'd20, 5'd0);
        chk("r41_pre_count", 32'(count), 32'd3);
        do_reset();
        in_valid = 1'b0; wr_ready = 1'b0; #1;
        chk("r41_count", 32'(count), 32'd0);
        chk("r41_wr_en", 32'(wr_en), 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd20, 5'd22);

        // Random traffic against the model
        for (int n = 0; n < 300; n++)
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        for (int n = 0; n < DEPTH + 1; n++) drive(0, 5'd0, 32'd0, 1, 5'd1, 5'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
